// File: rtl/ctrl_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : ctrl_sequencer_if
// Description : Single ready/valid memory port between the control sequencer
//               (master) and the memory subsystem (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ctrl_sequencer_if #(
  parameter int WORD_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
//------------------------------------------------------------------------------
// Module      : ctrl_sequencer
// Description : Fetch/execute control sequencer. Fetches a command word plus
//               up to NUM_ARGS arguments (immediate, direct, SP-relative,
//               PC-relative) over one memory port, then executes control-flow
//               and move operations. Optional interrupt entry is compiled in
//               with the CTRL_IRQ_EN macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_sequencer #(
  parameter int                WORD_W   = 16,
  parameter int                NUM_ARGS = 3,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h8000,
  parameter logic [WORD_W-1:0] RESET_SP = 16'hFFF0
`ifdef CTRL_IRQ_EN
  , parameter logic [WORD_W-1:0] IRQ_VECTOR = 16'h8010
`endif
) (
  input  logic              ctrl_clk,
  input  logic              reset,
  input  logic              enable,
  ctrl_sequencer_if.master  mem,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] sp,
  output logic              halted,
  output logic              busy
`ifdef CTRL_IRQ_EN
  , input  logic            irq
  , output logic            irq_ack
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ARG_IMM = 3'd2,
    S_ARG_IND = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [2:0]        c_OP_HALT  = 3'd0;
  localparam logic [2:0]        c_OP_MOVE  = 3'd1;
  localparam logic [2:0]        c_OP_JUMP  = 3'd2;
  localparam logic [2:0]        c_OP_JUMPZ = 3'd3;
  localparam logic [2:0]        c_OP_CALL  = 3'd4;
  localparam logic [2:0]        c_OP_SETSP = 3'd5;
  localparam logic [2:0]        c_OP_RET   = 3'd6;
  localparam logic [2:0]        c_OP_NOP   = 3'd7;
  localparam logic [WORD_W-1:0] c_ONE      = WORD_W'(1);

  state_t            r_state, w_state_n;
  logic [WORD_W-1:0] r_cmd, w_cmd_n;
  logic [WORD_W-1:0] r_arg [4];
  logic [WORD_W-1:0] w_arg_n [4];
  logic [1:0]        r_arg_idx, w_idx_n;
  logic [WORD_W-1:0] r_ind_addr, w_ind_n;
  logic [WORD_W-1:0] w_pc_n, w_sp_n;
  logic              w_halted_n, w_busy_n;
  logic              w_req_n, w_we_n;
  logic [WORD_W-1:0] w_addr_n, w_wdata_n;
  logic              w_xfer, w_arg_done;
  logic [2:0]        w_op, w_op_n;
  logic [1:0]        w_nargs;
  logic [5:0]        w_modes;
  logic              w_irq_cyc;
  logic [WORD_W-1:0] w_irq_vec;
  logic              w_unused;

`ifdef CTRL_IRQ_EN
  logic r_ie, w_ie_n;
  logic r_irq_cyc, w_irq_cyc_n;
  assign w_irq_cyc = r_irq_cyc;
  assign w_irq_vec = IRQ_VECTOR;
  assign irq_ack   = w_xfer & r_irq_cyc;
`else
  assign w_irq_cyc = 1'b0;
  assign w_irq_vec = '0;
`endif

  // Argument count field, clamped to the number of argument registers.
  function automatic logic [1:0] arg_count(input logic [WORD_W-1:0] c);
    if (int'(c[7:6]) > NUM_ARGS) return 2'(NUM_ARGS);
    return c[7:6];
  endfunction

  assign w_xfer   = mem.mem_req & mem.mem_ready;
  assign w_op     = r_cmd[WORD_W-1 -: 3];
  assign w_nargs  = arg_count(r_cmd);
  assign w_modes  = r_cmd[5:0];
  assign w_unused = ^{r_cmd[WORD_W-4:8], r_arg[2], r_arg[3]};

  // Next-state, datapath and port-register computation.
  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = pc;
    w_sp_n     = sp;
    w_halted_n = halted;
    w_cmd_n    = r_cmd;
    w_arg_n    = r_arg;
    w_idx_n    = r_arg_idx;
    w_ind_n    = r_ind_addr;
    w_arg_done = 1'b0;
    w_op_n     = 3'd0;
    // A completed transaction drops the request unless reissued below.
    w_req_n    = mem.mem_req & ~mem.mem_ready;
    w_we_n     = mem.mem_we;
    w_addr_n   = mem.mem_addr;
    w_wdata_n  = mem.mem_wdata;
`ifdef CTRL_IRQ_EN
    w_ie_n      = r_ie;
    w_irq_cyc_n = r_irq_cyc;
`endif

    case (r_state)
      S_IDLE: if (enable) w_state_n = S_CMD;

      S_CMD: if (w_xfer) begin
        if (w_irq_cyc) begin
          // Implicit call: return address already pushed, enter the vector.
          w_sp_n = sp + c_ONE;
          w_pc_n = w_irq_vec;
`ifdef CTRL_IRQ_EN
          w_ie_n      = 1'b0;
          w_irq_cyc_n = 1'b0;
`endif
        end else begin
          w_cmd_n   = mem.mem_rdata;
          w_pc_n    = pc + c_ONE;
          w_idx_n   = 2'd0;
          w_arg_n   = '{default: '0};
          w_state_n = (arg_count(mem.mem_rdata) == 2'd0) ? S_EXEC : S_ARG_IMM;
        end
      end

      S_ARG_IMM: if (w_xfer) begin
        w_pc_n = pc + c_ONE;
        case (w_modes[{r_arg_idx, 1'b0} +: 2])
          2'b00: begin
            w_arg_n[r_arg_idx] = mem.mem_rdata;
            w_arg_done         = 1'b1;
          end
          2'b01: begin
            w_ind_n   = mem.mem_rdata;
            w_state_n = S_ARG_IND;
          end
          2'b10: begin
            w_ind_n   = mem.mem_rdata + sp;
            w_state_n = S_ARG_IND;
          end
          default: begin
            // pc still holds the address of this argument word.
            w_ind_n   = mem.mem_rdata + pc;
            w_state_n = S_ARG_IND;
          end
        endcase
      end

      S_ARG_IND: if (w_xfer) begin
        w_arg_n[r_arg_idx] = mem.mem_rdata;
        w_arg_done         = 1'b1;
      end

      S_EXEC: case (w_op)
        c_OP_MOVE: if (w_xfer) w_state_n = S_CMD;
        c_OP_CALL: if (w_xfer) begin
          w_sp_n    = r_arg[1] + c_ONE;
          w_pc_n    = r_arg[0];
          w_state_n = S_CMD;
        end
        default: if (enable) begin
          w_state_n = S_CMD;
          case (w_op)
            c_OP_HALT: begin
              w_halted_n = 1'b1;
              w_state_n  = S_HALT;
            end
            c_OP_JUMP:  w_pc_n = r_arg[0];
            c_OP_JUMPZ: if (!r_arg[1][0]) w_pc_n = r_arg[0];
            c_OP_SETSP: w_sp_n = r_arg[0];
            c_OP_RET: begin
              w_pc_n = r_arg[0];
              w_sp_n = r_arg[1];
            end
            c_OP_NOP: begin
`ifdef CTRL_IRQ_EN
              if (r_arg[0][0]) w_ie_n = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      endcase

      default: ;
    endcase

    if (w_arg_done) begin
      if (r_arg_idx + 2'd1 < w_nargs) begin
        w_idx_n   = r_arg_idx + 2'd1;
        w_state_n = S_ARG_IMM;
      end else begin
        w_state_n = S_EXEC;
      end
    end

    // Issue the transaction owed by the state being entered (or one that was
    // deferred while enable was low). Only one transaction is ever in flight.
    w_op_n = w_cmd_n[WORD_W-1 -: 3];
    if (enable && !w_req_n) begin
      case (w_state_n)
        S_CMD: begin
          w_req_n  = 1'b1;
          w_we_n   = 1'b0;
          w_addr_n = w_pc_n;
`ifdef CTRL_IRQ_EN
          if (irq && w_ie_n) begin
            w_we_n      = 1'b1;
            w_addr_n    = w_sp_n;
            w_wdata_n   = w_pc_n;
            w_irq_cyc_n = 1'b1;
          end
`endif
        end
        S_ARG_IMM: begin
          w_req_n  = 1'b1;
          w_we_n   = 1'b0;
          w_addr_n = w_pc_n;
        end
        S_ARG_IND: begin
          w_req_n  = 1'b1;
          w_we_n   = 1'b0;
          w_addr_n = w_ind_n;
        end
        S_EXEC: begin
          if (w_op_n == c_OP_MOVE) begin
            w_req_n   = 1'b1;
            w_we_n    = 1'b1;
            w_addr_n  = w_arg_n[1];
            w_wdata_n = w_arg_n[0];
          end else if (w_op_n == c_OP_CALL) begin
            w_req_n   = 1'b1;
            w_we_n    = 1'b1;
            w_addr_n  = w_arg_n[1];
            w_wdata_n = w_pc_n;
          end
        end
        default: ;
      endcase
    end

    w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_HALT);
  end

  // State and architectural register update; reset also kills any request.
  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      pc            <= RESET_PC;
      sp            <= RESET_SP;
      halted        <= 1'b0;
      busy          <= 1'b0;
      r_cmd         <= '0;
      r_arg         <= '{default: '0};
      r_arg_idx     <= 2'd0;
      r_ind_addr    <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
`ifdef CTRL_IRQ_EN
      r_ie          <= 1'b1;
      r_irq_cyc     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_n;
      pc            <= w_pc_n;
      sp            <= w_sp_n;
      halted        <= w_halted_n;
      busy          <= w_busy_n;
      r_cmd         <= w_cmd_n;
      r_arg         <= w_arg_n;
      r_arg_idx     <= w_idx_n;
      r_ind_addr    <= w_ind_n;
      mem.mem_req   <= w_req_n;
      mem.mem_we    <= w_we_n;
      mem.mem_addr  <= w_addr_n;
      mem.mem_wdata <= w_wdata_n;
`ifdef CTRL_IRQ_EN
      r_ie          <= w_ie_n;
      r_irq_cyc     <= w_irq_cyc_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_ctrl_sequencer
// Description : Directed self-checking bench for ctrl_sequencer with a
//               behavioural memory slave and configurable ready stalls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ctrl_sequencer;

  logic        ctrl_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] pc, sp;
  logic        halted, busy;

  always #5 ctrl_clk = ~ctrl_clk;

  ctrl_sequencer_if #(.WORD_W(16)) bus ();

  ctrl_sequencer #(
    .WORD_W  (16),
    .NUM_ARGS(3),
    .RESET_PC(16'h8000),
    .RESET_SP(16'hFFF0)
  ) dut (
    .ctrl_clk(ctrl_clk),
    .reset   (reset),
    .enable  (enable),
    .mem     (bus),
    .pc      (pc),
    .sp      (sp),
    .halted  (halted),
    .busy    (busy)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } xact_t;

  logic [15:0] mem_model [0:65535];
  xact_t       log_q [$];
  int          stall_cycles = 0;
  int          wait_cnt;
  int          cyc = 0;
  int          stab_err = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic        prev_pend = 1'b0;
  logic        prev_we;
  logic [15:0] prev_addr, prev_wdata;

  // Memory slave: ready after stall_cycles waiting cycles, combinational data.
  assign bus.mem_ready = bus.mem_req && (wait_cnt >= stall_cycles);
  assign bus.mem_rdata = mem_model[bus.mem_addr];

  always @(posedge ctrl_clk or posedge reset) begin
    if (reset)                            wait_cnt <= 0;
    else if (bus.mem_req && bus.mem_ready) wait_cnt <= 0;
    else if (bus.mem_req)                  wait_cnt <= wait_cnt + 1;
  end

  // Transaction log, write-back into the model and request stability monitor.
  always @(negedge ctrl_clk) begin
    cyc++;
    if (!reset) begin
      if (prev_pend && !(bus.mem_req && bus.mem_we == prev_we &&
                         bus.mem_addr == prev_addr && bus.mem_wdata == prev_wdata))
        stab_err++;
      if (bus.mem_req && bus.mem_ready) begin
        log_q.push_back('{we: bus.mem_we, addr: bus.mem_addr,
                          data: bus.mem_we ? bus.mem_wdata : bus.mem_rdata, cyc: cyc});
        if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
      end
      prev_pend  = bus.mem_req && !bus.mem_ready;
      prev_we    = bus.mem_we;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_x(input string tag, input int i, input logic we,
                         input logic [15:0] addr, input logic [15:0] data);
    logic [32:0] obs;
    obs = 'x;
    if (i < log_q.size()) obs = {log_q[i].we, log_q[i].addr, log_q[i].data};
    check(tag, 64'(obs), 64'({we, addr, data}));
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem_model[a] = 16'h0000;
  endtask

  task automatic restart(input int stall);
    @(negedge ctrl_clk);
    reset        = 1'b1;
    enable       = 1'b1;
    stall_cycles = stall;
    repeat (2) @(posedge ctrl_clk);
    log_q.delete();
    stab_err = 0;
    @(negedge ctrl_clk);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge ctrl_clk);
      n++;
    end
    #1;
    check(tag, 64'(halted), 64'(1));
  endtask

  int gap;
  int n;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    clear_mem();
    repeat (2) @(posedge ctrl_clk);
    #1;
    check("rst_pc",     64'(pc),            64'(16'h8000));
    check("rst_sp",     64'(sp),            64'(16'hFFF0));
    check("rst_halted", 64'(halted),        64'(0));
    check("rst_busy",   64'(busy),          64'(0));
    check("rst_req",    64'(bus.mem_req),   64'(0));
    check("rst_we",     64'(bus.mem_we),    64'(0));
    check("rst_addr",   64'(bus.mem_addr),  64'(0));
    check("rst_wdata",  64'(bus.mem_wdata), 64'(0));

    // enable low: IDLE holds, no transactions.
    @(negedge ctrl_clk);
    reset = 1'b0;
    repeat (4) @(posedge ctrl_clk);
    #1;
    check("idle_req",  64'(bus.mem_req),  64'(0));
    check("idle_busy", 64'(busy),         64'(0));
    check("idle_log",  64'(log_q.size()), 64'(0));

    // NOP then HALT, ready tied high.
    clear_mem();
    mem_model[16'h8000] = 16'hE000;
    mem_model[16'h8001] = 16'h0000;
    restart(0);
    run_to_halt("t1_halt", 100);
    check("t1_pc",   64'(pc),   64'(16'h8002));
    check("t1_busy", 64'(busy), 64'(0));
    check_x("t1_rd0", 0, 1'b0, 16'h8000, 16'hE000);
    check_x("t1_rd1", 1, 1'b0, 16'h8001, 16'h0000);
    check("t1_count", 64'(log_q.size()), 64'(2));
    gap = -1;
    if (log_q.size() >= 2) gap = log_q[1].cyc - log_q[0].cyc;
    check("t1_nop_cycles", 64'(gap), 64'(2));

    // JUMP immediate.
    clear_mem();
    mem_model[16'h8000] = 16'h4040;
    mem_model[16'h8001] = 16'h1234;
    mem_model[16'h1234] = 16'h0000;
    restart(0);
    run_to_halt("t2_halt", 100);
    check_x("t2_target", 2, 1'b0, 16'h1234, 16'h0000);
    check("t2_pc", 64'(pc), 64'(16'h1235));
    check("t2_sp", 64'(sp), 64'(16'hFFF0));

    // MOVE direct source to immediate destination.
    clear_mem();
    mem_model[16'h8000] = 16'h2081;
    mem_model[16'h8001] = 16'h0050;
    mem_model[16'h8002] = 16'h0060;
    mem_model[16'h0050] = 16'hBEEF;
    mem_model[16'h8003] = 16'h0000;
    restart(0);
    run_to_halt("t3_halt", 100);
    check_x("t3_ind_rd", 2, 1'b0, 16'h0050, 16'hBEEF);
    check_x("t3_write",  4, 1'b1, 16'h0060, 16'hBEEF);
    check("t3_mem", 64'(mem_model[16'h0060]), 64'(16'hBEEF));
    check("t3_pc",  64'(pc), 64'(16'h8004));

    // CALL with SP-relative direct return-address slot.
    clear_mem();
    mem_model[16'h8000] = 16'h8088;
    mem_model[16'h8001] = 16'h9000;
    mem_model[16'h8002] = 16'h0002;
    mem_model[16'hFFF2] = 16'h0100;
    mem_model[16'h9000] = 16'h0000;
    restart(0);
    run_to_halt("t4_halt", 100);
    check_x("t4_sprel", 3, 1'b0, 16'hFFF2, 16'h0100);
    check_x("t4_push",  4, 1'b1, 16'h0100, 16'h8003);
    check_x("t4_fetch", 5, 1'b0, 16'h9000, 16'h0000);
    check("t4_sp", 64'(sp), 64'(16'h0101));
    check("t4_pc", 64'(pc), 64'(16'h9001));

    // NOP/HALT again with 3 stall cycles per transaction.
    clear_mem();
    mem_model[16'h8000] = 16'hE000;
    mem_model[16'h8001] = 16'h0000;
    restart(3);
    run_to_halt("t5_halt", 200);
    check("t5_pc", 64'(pc), 64'(16'h8002));
    check_x("t5_rd0", 0, 1'b0, 16'h8000, 16'hE000);
    check_x("t5_rd1", 1, 1'b0, 16'h8001, 16'h0000);
    check("t5_stable", 64'(stab_err), 64'(0));
    gap = -1;
    if (log_q.size() >= 2) gap = log_q[1].cyc - log_q[0].cyc;
    check("t5_stall_gap", 64'(gap), 64'(5));

    // Reset while the indirect read of a MOVE is stalled.
    clear_mem();
    mem_model[16'h8000] = 16'h2081;
    mem_model[16'h8001] = 16'h0050;
    mem_model[16'h8002] = 16'h0060;
    mem_model[16'h0050] = 16'hBEEF;
    mem_model[16'h8003] = 16'h0000;
    restart(3);
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 16'h0050) && n < 100) begin
      @(negedge ctrl_clk);
      n++;
    end
    check("t6_reach_ind", 64'(bus.mem_req && bus.mem_addr == 16'h0050), 64'(1));
    @(negedge ctrl_clk);
    #2 reset = 1'b1;
    #1;
    check("t6_req_drop", 64'(bus.mem_req), 64'(0));
    check("t6_pc",       64'(pc),          64'(16'h8000));
    check("t6_sp",       64'(sp),          64'(16'hFFF0));
    check("t6_no_write", 64'(mem_model[16'h0060]), 64'(16'h0000));
    repeat (2) @(posedge ctrl_clk);
    log_q.delete();
    @(negedge ctrl_clk);
    reset = 1'b0;
    run_to_halt("t6_halt", 300);
    check_x("t6_refetch", 0, 1'b0, 16'h8000, 16'h2081);
    check_x("t6_write",   4, 1'b1, 16'h0060, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
